// File: rtl/uart_boot_loader_p.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | uart_boot_loader_p : UART image loader / RAM dumper, owns RAM while boot  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module uart_boot_loader_p #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 6,
  parameter int CLKS_PER_BIT = 434,
  parameter int CHECKSUM_EN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              rx,
  output logic              tx,
  input  logic              scan_memory,
  output logic              boot,
  input  logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] ram_in,
  output logic [ADDR_W-1:0] ram_adr,
  output logic              ram_rw,
  output logic              ram_enable,
  output logic              load_done,
  output logic              cksum_err
);

  localparam int NBYTES = DATA_W / 8;
  localparam int BC_W   = $clog2(NBYTES + 1);
  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [ADDR_W-1:0] LAST_ADR = '1;

  typedef enum logic [2:0] {
    LOAD_BYTE, LOAD_WRITE, LOAD_CKSUM, FINISH, RUN, SCAN_READ, SCAN_LATCH, SCAN_TX
  } state_t;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d, rx_prev_q, rx_prev_d;
  logic sc_s1_q, sc_s1_d, sc_s2_q, sc_s2_d, sc_prev_q, sc_prev_d;

  rx_state_t        rx_st_q, rx_st_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sr_q, rx_sr_d;
  logic             rx_vld_q, rx_vld_d;
  logic [7:0]       rx_byte_q, rx_byte_d;

  logic             tx_busy_q, tx_busy_d;
  logic [CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]       tx_nbit_q, tx_nbit_d;
  logic [8:0]       tx_frame_q, tx_frame_d;
  logic             tx_q, tx_d;
  logic             tx_go;
  logic [7:0]       tx_byte;

  state_t            st_q, st_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [BC_W-1:0]   bcnt_q, bcnt_d;
  logic [7:0]        cksum_q, cksum_d;
  logic              boot_q, boot_d;
  logic [DATA_W-1:0] ram_in_q, ram_in_d;
  logic [ADDR_W-1:0] ram_adr_q, ram_adr_d;
  logic              ram_rw_q, ram_rw_d;
  logic              ram_enable_q, ram_enable_d;
  logic              load_done_q, load_done_d;
  logic              cksum_err_q, cksum_err_d;

  always_comb begin
    rx_s1_d      = rx;
    rx_s2_d      = rx_s1_q;
    rx_prev_d    = rx_s2_q;
    sc_s1_d      = scan_memory;
    sc_s2_d      = sc_s1_q;
    sc_prev_d    = sc_s2_q;
    rx_st_d      = rx_st_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_sr_d      = rx_sr_q;
    rx_vld_d     = 1'b0;
    rx_byte_d    = rx_byte_q;
    tx_busy_d    = tx_busy_q;
    tx_cnt_d     = tx_cnt_q;
    tx_nbit_d    = tx_nbit_q;
    tx_frame_d   = tx_frame_q;
    tx_d         = tx_q;
    tx_go        = 1'b0;
    tx_byte      = 8'h00;
    st_d         = st_q;
    word_d       = word_q;
    bcnt_d       = bcnt_q;
    cksum_d      = cksum_q;
    boot_d       = boot_q;
    ram_in_d     = ram_in_q;
    ram_adr_d    = ram_adr_q;
    ram_rw_d     = ram_rw_q;
    ram_enable_d = 1'b0;
    load_done_d  = load_done_q;
    cksum_err_d  = cksum_err_q;

    // Receiver: a start bit that is high again at mid-bit is a glitch
    case (rx_st_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s2_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_END) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_sr_d  = {rx_s2_q, rx_sr_q[7:1]};
          rx_bit_d = rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (rx_cnt_q == BIT_END) begin
          rx_cnt_d = '0;
          rx_st_d  = RX_IDLE;
          if (rx_s2_q) begin
            rx_vld_d  = 1'b1;
            rx_byte_d = rx_sr_q;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
    endcase

    case (st_q)
      LOAD_BYTE: begin
        if (rx_vld_q) begin
          word_d  = (word_q << 8) | DATA_W'(rx_byte_q);
          cksum_d = cksum_q ^ rx_byte_q;
          if (bcnt_q == BC_W'(NBYTES - 1)) begin
            bcnt_d       = '0;
            st_d         = LOAD_WRITE;
            ram_enable_d = 1'b1;
            ram_rw_d     = 1'b1;
            ram_in_d     = word_d;
          end else begin
            bcnt_d = bcnt_q + BC_W'(1);
          end
        end
      end
      LOAD_WRITE: begin
        ram_rw_d = 1'b0;
        if (ram_adr_q == LAST_ADR) begin
          st_d = (CHECKSUM_EN != 0) ? LOAD_CKSUM : FINISH;
        end else begin
          ram_adr_d = ram_adr_q + ADDR_W'(1);
          st_d      = LOAD_BYTE;
        end
      end
      LOAD_CKSUM: begin
        if (rx_vld_q) begin
          if (rx_byte_q != cksum_q) cksum_err_d = 1'b1;
          st_d = FINISH;
        end
      end
      FINISH: begin
        load_done_d = 1'b1;
        boot_d      = 1'b0;
        ram_adr_d   = '0;
        st_d        = RUN;
      end
      RUN: begin
        if (sc_s2_q && !sc_prev_q) begin
          boot_d       = 1'b1;
          ram_adr_d    = '0;
          ram_enable_d = 1'b1;
          ram_rw_d     = 1'b0;
          st_d         = SCAN_READ;
        end
      end
      SCAN_READ: st_d = SCAN_LATCH;
      SCAN_LATCH: begin
        word_d = ram_out;
        bcnt_d = '0;
        st_d   = SCAN_TX;
      end
      default: begin
        // Next byte (or next word) only once the previous stop bit has finished
        if (!tx_busy_q) begin
          if (bcnt_q == BC_W'(NBYTES)) begin
            if (ram_adr_q == LAST_ADR) begin
              ram_adr_d = '0;
              boot_d    = 1'b0;
              st_d      = RUN;
            end else begin
              ram_adr_d    = ram_adr_q + ADDR_W'(1);
              ram_enable_d = 1'b1;
              st_d         = SCAN_READ;
            end
          end else begin
            tx_go   = 1'b1;
            tx_byte = word_q[DATA_W-1 -: 8];
            word_d  = word_q << 8;
            bcnt_d  = bcnt_q + BC_W'(1);
          end
        end
      end
    endcase

    if (tx_go) begin
      tx_busy_d  = 1'b1;
      tx_cnt_d   = '0;
      tx_nbit_d  = 4'd0;
      tx_d       = 1'b0;
      tx_frame_d = {1'b1, tx_byte};
    end else if (tx_busy_q) begin
      if (tx_cnt_q == BIT_END) begin
        tx_cnt_d = '0;
        if (tx_nbit_q == 4'd9) begin
          tx_busy_d = 1'b0;
        end else begin
          tx_d       = tx_frame_q[0];
          tx_frame_d = {1'b1, tx_frame_q[8:1]};
          tx_nbit_d  = tx_nbit_q + 4'd1;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1_q      <= 1'b1;
      rx_s2_q      <= 1'b1;
      rx_prev_q    <= 1'b1;
      sc_s1_q      <= 1'b0;
      sc_s2_q      <= 1'b0;
      sc_prev_q    <= 1'b0;
      rx_st_q      <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sr_q      <= '0;
      rx_vld_q     <= 1'b0;
      rx_byte_q    <= '0;
      tx_busy_q    <= 1'b0;
      tx_cnt_q     <= '0;
      tx_nbit_q    <= '0;
      tx_frame_q   <= '1;
      tx_q         <= 1'b1;
      st_q         <= LOAD_BYTE;
      word_q       <= '0;
      bcnt_q       <= '0;
      cksum_q      <= '0;
      boot_q       <= 1'b1;
      ram_in_q     <= '0;
      ram_adr_q    <= '0;
      ram_rw_q     <= 1'b0;
      ram_enable_q <= 1'b0;
      load_done_q  <= 1'b0;
      cksum_err_q  <= 1'b0;
    end else if (ce) begin
      rx_s1_q      <= rx_s1_d;
      rx_s2_q      <= rx_s2_d;
      rx_prev_q    <= rx_prev_d;
      sc_s1_q      <= sc_s1_d;
      sc_s2_q      <= sc_s2_d;
      sc_prev_q    <= sc_prev_d;
      rx_st_q      <= rx_st_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_sr_q      <= rx_sr_d;
      rx_vld_q     <= rx_vld_d;
      rx_byte_q    <= rx_byte_d;
      tx_busy_q    <= tx_busy_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_nbit_q    <= tx_nbit_d;
      tx_frame_q   <= tx_frame_d;
      tx_q         <= tx_d;
      st_q         <= st_d;
      word_q       <= word_d;
      bcnt_q       <= bcnt_d;
      cksum_q      <= cksum_d;
      boot_q       <= boot_d;
      ram_in_q     <= ram_in_d;
      ram_adr_q    <= ram_adr_d;
      ram_rw_q     <= ram_rw_d;
      ram_enable_q <= ram_enable_d;
      load_done_q  <= load_done_d;
      cksum_err_q  <= cksum_err_d;
    end
  end

  assign tx         = tx_q;
  assign boot       = boot_q;
  assign ram_in     = ram_in_q;
  assign ram_adr    = ram_adr_q;
  assign ram_rw     = ram_rw_q;
  assign ram_enable = ram_enable_q;
  assign load_done  = load_done_q;
  assign cksum_err  = cksum_err_q;

endmodule
`default_nettype wire
